// File: rtl/dmem_responder_if.sv
// Data-memory bus and TX drain port bundles for dmem_responder.
// Core side drives addr/wd/we; the drain consumer drives tx_ready.
interface dmem_if;
  logic [31:0] addr;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rd;

  modport master (
    output addr, wd, we,
    input  rd
  );
  modport slave (
    input  addr, wd, we,
    output rd
  );
endinterface

interface tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready
  );
  modport slave (
    input  tx_data, tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/dmem_responder.sv
// Data RAM plus MMIO window: GPIO, cycle counter, byte TX FIFO.
// Reads are combinational; all state updates on posedge clk.
module dmem_responder #(
  parameter int          RAM_AW     = 9,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] GPIO_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  dmem_if.slave       bus,
  tx_if.master        tx,
  output logic [31:0] gpio_out,
  output logic        tx_overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = 1 << RAM_AW;

  logic [31:0]   mem [RW];
  logic [31:0]   gpio_q, gpio_d;
  logic [31:0]   cyc_q, cyc_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    fifo_q [FIFO_DEPTH];

  logic [9:0]  off;
  logic        io;
  logic        ram_sel, gpio_sel, cyc_sel, txd_sel, st_sel;
  logic        full, empty, push, pop, do_push, drop;
  logic [2:0]  cnt3;
  logic [31:0] status;
  logic        unused_ok;

  assign off = bus.addr[11:2];
  assign io  = bus.addr[11];

  assign ram_sel  = !io;
  assign gpio_sel = io && (off == 10'h200);
  assign cyc_sel  = io && (off == 10'h201);
  assign txd_sel  = io && (off == 10'h202);
  assign st_sel   = io && (off == 10'h203);

  assign unused_ok = ^{bus.addr[31:12], bus.addr[10:2],
                       bus.addr[1:0]};

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign push    = bus.we && txd_sel;
  assign pop     = tx.tx_valid && tx.tx_ready;
  // A full FIFO still accepts a push when the head leaves the same cycle
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  assign cnt3   = 3'(cnt_q);
  assign status = {25'b0, cnt3, 1'b0, ovf_q, full, empty};

  assign tx.tx_valid = !empty;
  assign tx.tx_data  = empty ? 8'h00 : fifo_q[rptr_q];
  assign gpio_out    = gpio_q;
  assign tx_overflow = ovf_q;

  always_comb begin
    bus.rd = 32'h0;
    unique case (1'b1)
      ram_sel:  bus.rd = mem[bus.addr[RAM_AW+1:2]];
      gpio_sel: bus.rd = gpio_q;
      cyc_sel:  bus.rd = cyc_q;
      st_sel:   bus.rd = status;
      default:  bus.rd = 32'h0;
    endcase
  end

  always_comb begin
    gpio_d = gpio_q;
    cyc_d  = cyc_q + 32'd1;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (bus.we && gpio_sel) gpio_d = bus.wd;
    if (bus.we && cyc_sel)  cyc_d  = 32'h0;
    if (do_push) wptr_d = wptr_q + PW'(1);
    if (pop)     rptr_d = rptr_q + PW'(1);
    unique case ({do_push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    // A dropped push outranks a same-cycle clear
    if (bus.we && st_sel) ovf_d = 1'b0;
    if (drop)             ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_q <= GPIO_RESET;
      cyc_q  <= 32'h0;
      ovf_q  <= 1'b0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      gpio_q <= gpio_d;
      cyc_q  <= cyc_d;
      ovf_q  <= ovf_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= 8'h00;
    end else if (do_push) begin
      fifo_q[wptr_q] <= bus.wd[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (bus.we && ram_sel) mem[bus.addr[RAM_AW+1:2]] <= bus.wd;
  end

endmodule
